pulse_train_controller: RTL and testbench

Output-side counterpart of the edge-counter controller: instead of counting edges on an input pin, it generates a programmed train of N pulses on an output pin. Each pulse has a programmable high and low duration. It sits in the `rtio_clk` domain behind the GPO core, which supplies `cmd_in`/`valid` on timestamp match. It writes one completion/abort report per train into the RTI FIFO for readback over AXI.

---
 rtl/pulse_train_controller.sv | 168 ++++++++++++++++
 tb/tb_pulse_train_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_controller.sv
// Purpose : generates a programmed train of N pulses (H cycles high, L low) on output_sig and posts one done/abort report per train.
// Latency : start -> output_sig high next cycle; train end/abort -> report write one cycle after the deciding cycle.
// Backpr. : none; commands that arrive while busy are dropped (abort excepted) and flag cmd_error.
// Ports   : clk, reset (sync, active-high); cmd_in/valid command from the GPO core; counter timestamp;
//           output_sig pulse pin; busy train in progress; write/report_out RTI FIFO entry; cmd_error sticky.
module pulse_train_controller #(
  parameter int DATA_WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  cmd_in,
  input  logic         valid,
  input  logic [63:0]  counter,
  output logic         output_sig,
  output logic         busy,
  output logic         write,
  output logic [127:0] report_out,
  output logic         cmd_error
);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_ABORT = 2'b01;
  localparam logic [1:0] OP_LEVEL = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b00;
  localparam logic [1:0] ST_ABORT = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HIGH = 2'b01,
    S_LOW  = 2'b10
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] n_reg;
  logic [DATA_WIDTH-1:0] h_reg;
  logic [DATA_WIDTH-1:0] l_reg;
  logic [DATA_WIDTH-1:0] phase_cnt;
  logic [DATA_WIDTH-1:0] emitted;
  logic                  level_reg;

  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] cmd_n;
  logic [DATA_WIDTH-1:0] cmd_h;
  logic [DATA_WIDTH-1:0] cmd_l;
  logic [DATA_WIDTH-1:0] h_eff;
  logic [DATA_WIDTH-1:0] l_eff;
  logic                  is_abort;
  logic                  is_set;

  // Bits above the command fields carry nothing; fold them so they are consumed.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_in;

  assign op       = cmd_in[63:62];
  assign cmd_n    = cmd_in[0  +: DATA_WIDTH];
  assign cmd_h    = cmd_in[16 +: DATA_WIDTH];
  assign cmd_l    = cmd_in[32 +: DATA_WIDTH];
  // A zero-length phase still lasts one cycle.
  assign h_eff    = (cmd_h == '0) ? DATA_WIDTH'(1) : cmd_h;
  assign l_eff    = (cmd_l == '0) ? DATA_WIDTH'(1) : cmd_l;
  assign is_abort = valid && (op == OP_ABORT);
  assign is_set   = valid && ((op == OP_START) || (op == OP_LEVEL));

  function automatic logic [127:0] make_report(input logic [63:0] ts,
                                               input logic [1:0] status,
                                               input logic [DATA_WIDTH-1:0] count);
    logic [127:0] r;
    r                 = '0;
    r[127:64]         = ts;
    r[63:62]          = status;
    r[DATA_WIDTH-1:0] = count;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      n_reg      <= '0;
      h_reg      <= '0;
      l_reg      <= '0;
      phase_cnt  <= '0;
      emitted    <= '0;
      level_reg  <= 1'b0;
      output_sig <= 1'b0;
      busy       <= 1'b0;
      write      <= 1'b0;
      report_out <= '0;
      cmd_error  <= 1'b0;
    end else begin
      write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid && op == OP_START) begin
            if (cmd_n == '0) begin
              // Empty train: report immediately, pin untouched.
              write      <= 1'b1;
              report_out <= make_report(counter, ST_DONE, '0);
            end else begin
              n_reg      <= cmd_n;
              h_reg      <= h_eff;
              l_reg      <= l_eff;
              emitted    <= DATA_WIDTH'(1);
              phase_cnt  <= DATA_WIDTH'(1);
              state      <= S_HIGH;
              output_sig <= 1'b1;
              busy       <= 1'b1;
            end
          end else if (valid && op == OP_LEVEL) begin
            level_reg  <= cmd_in[0];
            output_sig <= cmd_in[0];
          end
        end

        S_HIGH, S_LOW: begin
          if (is_abort) begin
            // A high phase already entered counts as emitted.
            state      <= S_IDLE;
            output_sig <= 1'b0;
            busy       <= 1'b0;
            level_reg  <= 1'b0;
            write      <= 1'b1;
            report_out <= make_report(counter, ST_ABORT, emitted);
          end else begin
            if (is_set) begin
              cmd_error <= 1'b1;
            end
            // phase_cnt holds the 1-based cycle index within the current phase.
            if (state == S_HIGH) begin
              if (phase_cnt == h_reg) begin
                if (emitted == n_reg) begin
                  state      <= S_IDLE;
                  output_sig <= 1'b0;
                  busy       <= 1'b0;
                  level_reg  <= 1'b0;
                  write      <= 1'b1;
                  report_out <= make_report(counter, ST_DONE, emitted);
                end else begin
                  state      <= S_LOW;
                  phase_cnt  <= DATA_WIDTH'(1);
                  output_sig <= 1'b0;
                end
              end else begin
                phase_cnt <= phase_cnt + DATA_WIDTH'(1);
              end
            end else begin
              if (phase_cnt == l_reg) begin
                state      <= S_HIGH;
                phase_cnt  <= DATA_WIDTH'(1);
                emitted    <= emitted + DATA_WIDTH'(1);
                output_sig <= 1'b1;
              end else begin
                phase_cnt <= phase_cnt + DATA_WIDTH'(1);
              end
            end
          end
        end

        default: begin
          state      <= S_IDLE;
          output_sig <= 1'b0;
          busy       <= 1'b0;
          level_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_controller.sv
module tb_pulse_train_controller;

  localparam logic [63:0] TS_BASE = 64'h0123_4567_0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  cmd_in;
  logic         valid;
  logic [63:0]  counter;
  logic         output_sig;
  logic         busy;
  logic         write;
  logic [127:0] report_out;
  logic         cmd_error;

  always #5 clk = ~clk;

  pulse_train_controller #(.DATA_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_in     (cmd_in),
    .valid      (valid),
    .counter    (counter),
    .output_sig (output_sig),
    .busy       (busy),
    .write      (write),
    .report_out (report_out),
    .cmd_error  (cmd_error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic sig;
    logic bsy;
    logic wr;
    logic err;
  } wexp_t;

  wexp_t        wq[$];
  logic [127:0] rq[$];
  bit           mon_en = 1'b0;

  // Reference model: a train is described by its start cycle and lengths;
  // everything else follows arithmetically from those.
  bit m_active = 1'b0;
  int m_t = 0, m_n = 0, m_h = 1, m_l = 1, m_e = 0;
  bit m_level = 1'b0;
  bit m_err = 1'b0;

  function automatic logic [127:0] rep(input logic [63:0] ts, input logic [1:0] st, input int cnt);
    logic [127:0] r;
    r          = '0;
    r[127:64]  = ts;
    r[63:62]   = st;
    r[15:0]    = cnt[15:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wexp_t e;
    if (mon_en) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wave_queue_underflow @cycle %0d: got empty want entry", cyc);
      end else begin
        e = wq.pop_front();
        chk("output_sig", 128'(output_sig), 128'(e.sig));
        chk("busy",       128'(busy),       128'(e.bsy));
        chk("write",      128'(write),      128'(e.wr));
        chk("cmd_error",  128'(cmd_error),  128'(e.err));
      end
      if (write === 1'b1) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL report_unexpected @cycle %0d: got %h want none", cyc, report_out);
        end else begin
          chk("report", report_out, rq.pop_front());
        end
      end
    end
  end

  // Drive one cycle of input and advance the model to predict the next cycle.
  task automatic step(input bit rst, input bit v, input logic [1:0] op,
                      input int n, input int h, input int l);
    int    c;
    int    cnt;
    int    p;
    bit    wr;
    wexp_t x;
    @(negedge clk);
    c       = cyc;
    reset   = rst;
    valid   = v;
    cmd_in  = {op, 14'($urandom), l[15:0], h[15:0], n[15:0]};
    counter = TS_BASE + 64'(c);
    wr      = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_level  = 1'b0;
      m_err    = 1'b0;
    end else begin
      if (m_active) begin
        if (v && op == 2'b01) begin
          cnt = (c - m_t - 1) / (m_h + m_l) + 1;
          if (cnt > m_n) cnt = m_n;
          rq.push_back(rep(counter, 2'b01, cnt));
          wr       = 1'b1;
          m_active = 1'b0;
          m_level  = 1'b0;
        end else if (v && (op == 2'b00 || op == 2'b10)) begin
          m_err = 1'b1;
        end
      end else if (v) begin
        if (op == 2'b00) begin
          if (n == 0) begin
            rq.push_back(rep(counter, 2'b00, 0));
            wr = 1'b1;
          end else begin
            m_active = 1'b1;
            m_t      = c;
            m_n      = n;
            m_h      = (h == 0) ? 1 : h;
            m_l      = (l == 0) ? 1 : l;
            m_e      = c + (n - 1) * (m_h + m_l) + m_h + 1;
          end
        end else if (op == 2'b10) begin
          m_level = n[0];
        end
      end
      if (m_active && (c + 1 == m_e)) begin
        rq.push_back(rep(counter, 2'b00, m_n));
        wr       = 1'b1;
        m_active = 1'b0;
        m_level  = 1'b0;
      end
    end
    if (m_active) begin
      p     = (c - m_t) % (m_h + m_l);
      x.sig = (p < m_h);
      x.bsy = 1'b1;
    end else begin
      x.sig = m_level;
      x.bsy = 1'b0;
    end
    x.wr  = wr;
    x.err = m_err;
    wq.push_back(x);
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, 2'b11, 0, 0, 0);
  endtask

  task automatic cmd(input logic [1:0] op, input int n, input int h, input int l);
    step(1'b0, 1'b1, op, n, h, l);
  endtask

  initial begin
    reset   = 1'b1;
    valid   = 1'b0;
    cmd_in  = '0;
    counter = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_output_sig", 128'(output_sig), 128'(0));
    chk("reset_busy",       128'(busy),       128'(0));
    chk("reset_write",      128'(write),      128'(0));
    chk("reset_report_out", report_out,       128'(0));
    chk("reset_cmd_error",  128'(cmd_error),  128'(0));
    @(posedge clk);
    wq.push_back('0);
    mon_en = 1'b1;

    // Normal train N=2 H=3 L=2.
    cmd(2'b00, 2, 3, 2);   idle(12);
    // Zero-length phases.
    cmd(2'b00, 1, 0, 0);   idle(4);
    // Empty train.
    cmd(2'b00, 0, 5, 5);   idle(3);
    // Abort during the third high phase (19 cycles after start).
    cmd(2'b00, 5, 4, 4);   idle(18);
    cmd(2'b01, 0, 0, 0);   idle(10);
    // Start and set-level while busy, then abort while idle.
    cmd(2'b00, 3, 2, 2);   idle(1);
    cmd(2'b00, 4, 1, 1);   idle(2);
    cmd(2'b10, 1, 0, 0);   idle(15);
    cmd(2'b01, 0, 0, 0);   idle(3);
    // Level followed by a train; opcode 11 ignored.
    cmd(2'b10, 1, 0, 0);   idle(2);
    cmd(2'b11, 3, 1, 1);   idle(2);
    cmd(2'b00, 1, 1, 1);   idle(4);
    // Reset mid-train.
    cmd(2'b00, 4, 3, 3);   idle(5);
    step(1'b1, 1'b0, 2'b11, 0, 0, 0);
    idle(3);
    // New start in the cycle busy falls.
    cmd(2'b00, 1, 2, 0);   idle(2);
    cmd(2'b00, 2, 1, 1);   idle(6);
    // Abort on the final high cycle.
    cmd(2'b00, 2, 2, 1);   idle(4);
    cmd(2'b01, 0, 0, 0);   idle(3);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(1'b1, 1'b0, 2'b11, 0, 0, 0);
      end else begin
        step(1'b0, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end
    idle(40);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("report_queue_drained", 128'(rq.size()), 128'(0));
    chk("wave_queue_drained",   128'(wq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
